// File: rtl/instructions_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Default machine width, fetch-buffer depth and the fetch FSM state encoding.
package instructions_pkg;

    localparam int X_LEN            = 32;
    localparam int FETCH_FIFO_DEPTH = 4;
    localparam int PC_STEP          = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode handshakes of the fetch unit.
// Handshake rule for every valid/ready pair here: a transfer happens on a rising clk
// edge where valid and ready are both 1; the memory response has no ready and is
// accepted unconditionally in the cycle it is valid.
interface fetch_unit_if #(
    parameter int X_LEN = instructions_pkg::X_LEN
);

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [X_LEN-1:0] imem_req_addr;
    logic             imem_resp_valid;
    logic [X_LEN-1:0] imem_resp_data;
    logic             inst_valid;
    logic             inst_ready;
    logic [X_LEN-1:0] inst;
    logic [X_LEN-1:0] inst_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch buffer with push/pop/clear and an occupancy count.
// Head data is read combinationally; push and pop in the same cycle are legal at full and empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop & ~empty;
    // At full, a push only fits when the head leaves in the same cycle.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order responses
// and drops stale responses after a redirect. Optional macro: FETCH_MISALIGN_EN.
module fetch_unit
    import instructions_pkg::*;
#(
    parameter int X_LEN      = instructions_pkg::X_LEN,
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [X_LEN-1:0]  boot_addr,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [X_LEN-1:0]  redirect_pc,
    fetch_unit_if.master      bus,
    output logic              misaligned,
    output fetch_state_t      dbg_state,
    output logic [CW-1:0]     dbg_inflight,
    output logic [CW-1:0]     dbg_discard_cnt,
    output logic [CW-1:0]     dbg_fifo_count
);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [X_LEN-1:0] fetch_pc;
    logic [X_LEN-1:0] resp_pc;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    discard_cnt;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic [2*X_LEN-1:0] fifo_head;
    logic             mis_q;
    logic             credit_ok;
    logic             req_valid;
    logic             req_hs;
    logic             resp_keep;
    logic             pop;
    logic [X_LEN-1:0] redirect_target;

    assign redirect_target = redirect_pc & ~X_LEN'(3);

    // Outstanding requests plus buffered entries never exceed the buffer depth,
    // so every response that is kept always has a slot waiting for it.
    assign credit_ok = ((CW+1)'(inflight) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        case (state)
            IDLE: if (fetch_en)  state_next = RUN;
            RUN:  if (!fetch_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state == RUN && fetch_en && !redirect_valid && credit_ok && !mis_q) begin
            req_valid = 1'b1;
        end
    end

    assign req_hs    = req_valid & bus.imem_req_ready;
    assign resp_keep = bus.imem_resp_valid & ~redirect_valid & (discard_cnt == '0);
    assign pop       = ~fifo_empty & bus.inst_ready & ~redirect_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= boot_addr;
            resp_pc     <= boot_addr;
            inflight    <= '0;
            discard_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(req_hs) - CW'(bus.imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc    <= redirect_target;
                resp_pc     <= redirect_target;
                // Everything still outstanding after this cycle belongs to the old stream.
                discard_cnt <= inflight - CW'(bus.imem_resp_valid);
            end else begin
                if (req_hs) begin
                    fetch_pc <= fetch_pc + X_LEN'(PC_STEP);
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + X_LEN'(PC_STEP);
                end
                if (bus.imem_resp_valid && discard_cnt != '0) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_EN
    // Sticky until a word-aligned redirect arrives; fetch stays blocked meanwhile.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mis_q <= 1'b0;
        end else if (redirect_valid) begin
            mis_q <= |redirect_pc[1:0];
        end
    end
`else
    assign mis_q = 1'b0;
`endif

    fetch_fifo #(
        .WIDTH (2 * X_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (redirect_valid),
        .push      (resp_keep),
        .push_data ({resp_pc, bus.imem_resp_data}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = ~fifo_empty;
    assign bus.inst_pc        = fifo_head[2*X_LEN-1:X_LEN];
    assign bus.inst           = fifo_head[X_LEN-1:0];

    assign misaligned      = mis_q;
    assign dbg_state       = state;
    assign dbg_inflight    = inflight;
    assign dbg_discard_cnt = discard_cnt;
    assign dbg_fifo_count  = fifo_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency,
// instruction-stream reference (generation-tagged requests) and directed scenarios.
module tb_fetch_unit;
  import instructions_pkg::*;

  localparam int XL    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rstn;
  logic [XL-1:0] boot_addr;
  logic fetch_en;
  logic redirect_valid;
  logic [XL-1:0] redirect_pc;
  logic misaligned;
  fetch_state_t dbg_state;
  logic [CW-1:0] dbg_inflight;
  logic [CW-1:0] dbg_discard_cnt;
  logic [CW-1:0] dbg_fifo_count;

  always #5 clk = ~clk;

  fetch_unit_if #(.X_LEN(XL)) bus ();

  fetch_unit #(.X_LEN(XL), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .boot_addr       (boot_addr),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .bus             (bus),
    .misaligned      (misaligned),
    .dbg_state       (dbg_state),
    .dbg_inflight    (dbg_inflight),
    .dbg_discard_cnt (dbg_discard_cnt),
    .dbg_fifo_count  (dbg_fifo_count)
  );

  typedef struct {
    logic [XL-1:0] addr;
    int            due;
    int            gen;
  } mreq_t;

  mreq_t         mem_q[$];
  logic [XL-1:0] exp_q[$];
  logic [XL-1:0] hs_log[$];
  logic [XL-1:0] pop_pc[$];
  int            pop_cyc[$];

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int gen = 0;
  int hs_cnt = 0;
  int lat_min = 1;
  int lat_max = 1;
  int rdy_pct = 100;
  int inst_pct = 100;
  logic [XL-1:0] model_req_pc;
  logic model_mis = 1'b0;
  logic prev_pend = 1'b0;
  logic [XL-1:0] prev_addr;

  function automatic logic [XL-1:0] mem_data(input logic [XL-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c96_a55a;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].gen != gen) n++;
    return n;
  endfunction

  // One clock cycle: drive memory side, sample at negedge, check, advance the model.
  task automatic tick();
    logic rsp, rv, rdy, iv, ird;
    logic [XL-1:0] ra, ipc, ins;
    mreq_t m;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.imem_resp_valid = rsp;
    if (rsp) bus.imem_resp_data = mem_data(mem_q[0].addr);
    else     bus.imem_resp_data = $urandom();
    bus.imem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
    bus.inst_ready     = ($urandom_range(1, 100) <= inst_pct);
    @(negedge clk);
    rv = bus.imem_req_valid; ra = bus.imem_req_addr; rdy = bus.imem_req_ready;
    iv = bus.inst_valid; ipc = bus.inst_pc; ins = bus.inst; ird = bus.inst_ready;
    vec++;
    if (iv !== (exp_q.size() != 0)) begin
      err++; $display("FAIL inst_valid cyc=%0d: got %b want %b", cyc, iv, exp_q.size() != 0);
    end
    if (iv === 1'b1 && exp_q.size() > 0) begin
      vec++;
      if (ipc !== exp_q[0]) begin
        err++; $display("FAIL inst_pc cyc=%0d: got %h want %h", cyc, ipc, exp_q[0]);
      end
      vec++;
      if (ins !== mem_data(exp_q[0])) begin
        err++; $display("FAIL inst_data cyc=%0d: got %h want %h", cyc, ins, mem_data(exp_q[0]));
      end
    end
    if (rv === 1'b1) begin
      vec++;
      if (ra !== model_req_pc) begin
        err++; $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, ra, model_req_pc);
      end
      vec++;
      if (redirect_valid || !fetch_en || model_mis || (mem_q.size() + exp_q.size() >= DEPTH)) begin
        err++; $display("FAIL req_gate cyc=%0d: got valid=1 want 0 (out=%0d buf=%0d)",
                        cyc, mem_q.size(), exp_q.size());
      end
    end
    if (prev_pend && fetch_en && !redirect_valid && !model_mis) begin
      vec++;
      if (rv !== 1'b1 || ra !== prev_addr) begin
        err++; $display("FAIL req_hold cyc=%0d: got %b/%h want 1/%h", cyc, rv, ra, prev_addr);
      end
    end
    vec++;
    if (misaligned !== model_mis) begin
      err++; $display("FAIL misaligned cyc=%0d: got %b want %b", cyc, misaligned, model_mis);
    end
    prev_pend = (rv === 1'b1) && !rdy;
    prev_addr = ra;
    if (iv === 1'b1 && ird && !redirect_valid && exp_q.size() > 0) begin
      pop_pc.push_back(exp_q[0]);
      pop_cyc.push_back(cyc);
      void'(exp_q.pop_front());
    end
    if (rsp) begin
      m = mem_q.pop_front();
      if (!redirect_valid && m.gen == gen) exp_q.push_back(m.addr);
    end
    if (rv === 1'b1 && rdy) begin
      m.addr = ra;
      m.due  = cyc + $urandom_range(lat_min, lat_max);
      m.gen  = gen;
      mem_q.push_back(m);
      model_req_pc = model_req_pc + 32'd4;
      hs_cnt++;
      hs_log.push_back(ra);
    end
    if (redirect_valid) begin
      exp_q.delete();
      gen++;
      model_req_pc = {redirect_pc[XL-1:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
      model_mis = |redirect_pc[1:0];
`endif
      prev_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [XL-1:0] boot);
    rstn = 1'b0;
    boot_addr = boot;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.inst_ready = 1'b0;
    #2;
    mem_q.delete();
    exp_q.delete();
    hs_log.delete();
    pop_pc.delete();
    pop_cyc.delete();
    gen++;
    hs_cnt = 0;
    model_req_pc = boot;
    model_mis = 1'b0;
    prev_pend = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    vec++;
    if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || misaligned !== 1'b0) begin
      err++; $display("FAIL %s_outs: got req=%b inst=%b mis=%b want 0/0/0", tag,
                      bus.imem_req_valid, bus.inst_valid, misaligned);
    end
    vec++;
    if (dbg_state !== IDLE || dbg_inflight !== '0 || dbg_discard_cnt !== '0 || dbg_fifo_count !== '0) begin
      err++; $display("FAIL %s_state: got st=%0d inf=%0d disc=%0d cnt=%0d want 0/0/0/0", tag,
                      dbg_state, dbg_inflight, dbg_discard_cnt, dbg_fifo_count);
    end
  endtask

  task automatic test_reset();
    do_reset(32'h0000_0100);
    check_reset_outputs("reset");
    release_reset();
    repeat (3) tick();
    vec++;
    if (hs_cnt != 0) begin
      err++; $display("FAIL idle_no_req: got %0d requests want 0", hs_cnt);
    end
  endtask

  task automatic test_stream();
    int c0;
    do_reset(32'h0000_0100);
    release_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; inst_pct = 100;
    fetch_en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 20 && pop_pc.size() < 3; i++) tick();
    vec++;
    if (pop_pc.size() < 3) begin
      err++; $display("FAIL stream_timeout: got %0d insts want 3", pop_pc.size());
    end else begin
      vec++;
      if (pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104 || pop_pc[2] !== 32'h108) begin
        err++; $display("FAIL stream_pcs: got %h %h %h want 100 104 108", pop_pc[0], pop_pc[1], pop_pc[2]);
      end
      vec++;
      if (pop_cyc[0] != c0 + 3 || pop_cyc[1] != c0 + 4 || pop_cyc[2] != c0 + 5) begin
        err++; $display("FAIL stream_timing: got %0d %0d %0d want %0d %0d %0d",
                        pop_cyc[0] - c0, pop_cyc[1] - c0, pop_cyc[2] - c0, 3, 4, 5);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(32'h0000_0400);
    release_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; inst_pct = 0;
    fetch_en = 1'b1;
    repeat (15) tick();
    vec++;
    if (hs_cnt != 4) begin
      err++; $display("FAIL bp_count: got %0d requests want 4", hs_cnt);
    end
    vec++;
    if (bus.imem_req_valid !== 1'b0 || dbg_fifo_count !== CW'(4)) begin
      err++; $display("FAIL bp_full: got req=%b cnt=%0d want 0/4", bus.imem_req_valid, dbg_fifo_count);
    end
    inst_pct = 100;
    tick();
    inst_pct = 0;
    for (int i = 0; i < 6 && hs_cnt < 5; i++) tick();
    vec++;
    if (hs_cnt != 5 || hs_log[4] !== 32'h410) begin
      err++; $display("FAIL bp_resume: got %0d reqs last %h want 5 reqs last 410", hs_cnt, hs_log[hs_log.size()-1]);
    end
    inst_pct = 100;
    repeat (10) tick();
  endtask

  task automatic test_redirect_inflight();
    do_reset(32'h0000_1000);
    release_reset();
    lat_min = 6; lat_max = 6; rdy_pct = 100; inst_pct = 100;
    fetch_en = 1'b1;
    for (int i = 0; i < 20 && mem_q.size() < 3; i++) tick();
    vec++;
    if (mem_q.size() != 3) begin
      err++; $display("FAIL redir_setup: got %0d outstanding want 3", mem_q.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    vec++;
    if (dbg_discard_cnt !== CW'(stale_cnt()) || stale_cnt() != 3) begin
      err++; $display("FAIL redir_discard: got %0d want %0d", dbg_discard_cnt, stale_cnt());
    end
    hs_log.delete();
    pop_pc.delete();
    tick();
    vec++;
    if (hs_log.size() != 1 || hs_log[0] !== 32'h200) begin
      err++; $display("FAIL redir_first_req: got %0d reqs want 1 at 200", hs_log.size());
    end
    for (int i = 0; i < 40 && pop_pc.size() < 1; i++) tick();
    vec++;
    if (pop_pc.size() < 1 || pop_pc[0] !== 32'h200) begin
      err++; $display("FAIL redir_first_inst: got %0d insts want first 200", pop_pc.size());
    end
  endtask

  task automatic test_redirect_collide();
    int n_out;
    do_reset(32'h0000_2000);
    release_reset();
    lat_min = 3; lat_max = 3; rdy_pct = 100; inst_pct = 100;
    fetch_en = 1'b1;
    for (int i = 0; i < 30 && !(mem_q.size() > 1 && mem_q[0].due <= cyc && exp_q.size() > 0); i++) tick();
    n_out = mem_q.size();
    vec++;
    if (!(n_out > 1 && mem_q[0].due <= cyc && exp_q.size() > 0)) begin
      err++; $display("FAIL collide_setup: got out=%0d buf=%0d want resp+pop pending", n_out, exp_q.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2400;
    tick();
    redirect_valid = 1'b0;
    vec++;
    if (bus.inst_valid !== 1'b0 || dbg_fifo_count !== '0) begin
      err++; $display("FAIL collide_empty: got valid=%b cnt=%0d want 0/0", bus.inst_valid, dbg_fifo_count);
    end
    vec++;
    if (dbg_discard_cnt !== CW'(n_out - 1)) begin
      err++; $display("FAIL collide_discard: got %0d want %0d", dbg_discard_cnt, n_out - 1);
    end
    repeat (20) tick();
  endtask

  task automatic test_wrap();
    do_reset(32'hFFFF_FFF0);
    release_reset();
    lat_min = 1; lat_max = 2; rdy_pct = 100; inst_pct = 100;
    fetch_en = 1'b1;
    for (int i = 0; i < 30 && hs_log.size() < 6; i++) tick();
    vec++;
    if (hs_log.size() < 6 || hs_log[3] !== 32'hFFFF_FFFC || hs_log[4] !== 32'h0000_0000) begin
      err++; $display("FAIL wrap_addr: got %0d reqs want ...fffc then 00000000", hs_log.size());
    end
    repeat (10) tick();
  endtask

  task automatic test_misalign();
    do_reset(32'h0000_0500);
    release_reset();
    lat_min = 1; lat_max = 3; rdy_pct = 100; inst_pct = 100;
    fetch_en = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    tick();
    redirect_valid = 1'b0;
    hs_log.delete();
    repeat (8) tick();
`ifdef FETCH_MISALIGN_EN
    vec++;
    if (misaligned !== 1'b1) begin
      err++; $display("FAIL mis_flag: got %b want 1", misaligned);
    end
    vec++;
    if (hs_log.size() != 0) begin
      err++; $display("FAIL mis_block: got %0d reqs want 0", hs_log.size());
    end
`else
    vec++;
    if (misaligned !== 1'b0) begin
      err++; $display("FAIL mis_tied: got %b want 0", misaligned);
    end
    vec++;
    if (hs_log.size() == 0 || hs_log[0] !== 32'h200) begin
      err++; $display("FAIL mis_forced: got %0d reqs want first at 200", hs_log.size());
    end
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    hs_log.delete();
    for (int i = 0; i < 10 && hs_log.size() < 1; i++) tick();
    vec++;
    if (misaligned !== 1'b0 || hs_log.size() < 1 || hs_log[0] !== 32'h300) begin
      err++; $display("FAIL mis_resume: got mis=%b reqs=%0d want 0 and first at 300", misaligned, hs_log.size());
    end
    repeat (10) tick();
  endtask

  task automatic test_random();
    do_reset({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    release_reset();
    lat_min = 1; lat_max = 4; rdy_pct = 70; inst_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      fetch_en = ($urandom_range(0, 9) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom();
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      tick();
    end
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    lat_min = 2; lat_max = 4; rdy_pct = 100; inst_pct = 30;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_8000;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    do_reset(32'h0000_0a00);
    check_reset_outputs("reset_mid");
    release_reset();
    inst_pct = 100;
    fetch_en = 1'b1;
    for (int i = 0; i < 20 && pop_pc.size() < 1; i++) tick();
    vec++;
    if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0000_0a00) begin
      err++; $display("FAIL reset_mid_boot: got %0d insts want first at a00", pop_pc.size());
    end
  endtask

  initial begin
    rstn = 1'b1;
    boot_addr = '0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.inst_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
